encrypter_top_level: RTL and testbench

ENCRYPTER_TOP_LEVEL -- requirements
Module: encrypter_top_level

---
 rtl/enc_pkg.sv | 34 +++
 rtl/lfsr5.sv | 24 ++
 rtl/encrypter_top_level.sv | 120 ++++++++++++
 tb/tb_encrypter_top_level.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared constants, FSM state type and helpers for the preamble/LFSR encrypter.
package enc_pkg;

    // Feedback tap patterns, selected by tap_sel.
    localparam logic [4:0] LFSR_PTRN [6] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h14, 5'h12};

    localparam int unsigned MSG_BASE  = 0;
    localparam int unsigned ENC_BASE  = 64;
    localparam int unsigned MSG_TOTAL = 64;
    localparam int unsigned PRE_MIN   = 6;
    localparam int unsigned PRE_MAX   = 12;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} enc_state_e;

    // Effective preamble length, clamped to PRE_MIN..PRE_MAX.
    function automatic logic [3:0] clamp_pre_len(input logic [3:0] len);
        if (len < 4'(PRE_MIN)) return 4'(PRE_MIN);
        if (len > 4'(PRE_MAX)) return 4'(PRE_MAX);
        return len;
    endfunction

    // Tap pattern lookup; out-of-range selectors fall back to pattern 0.
    function automatic logic [4:0] tap_pattern(input logic [2:0] sel);
        case (sel)
            3'd1:    return LFSR_PTRN[1];
            3'd2:    return LFSR_PTRN[2];
            3'd3:    return LFSR_PTRN[3];
            3'd4:    return LFSR_PTRN[4];
            3'd5:    return LFSR_PTRN[5];
            default: return LFSR_PTRN[0];
        endcase
    endfunction

endpackage

// File: rtl/lfsr5.sv
// 5-bit Fibonacci LFSR: shifts left, feedback bit is the parity of state & taps.
module lfsr5 (
    input  logic       clk,
    input  logic       en,
    input  logic       init,
    input  logic [4:0] taps,
    input  logic [4:0] start,
    output logic [4:0] state
);

    logic [4:0] r_state;

    // Load has priority over advance.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= start;
        end else if (en) begin
            r_state <= {r_state[3:0], ^(r_state & taps)};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/encrypter_top_level.sv
// Preamble + LFSR encrypter: reads plaintext from mem[0..63], writes ciphertext to
// mem[64..127]. Define ENC_TRACE_EN to print each ciphertext write.
module encrypter_top_level
    import enc_pkg::*;
(
    input  logic       clk,
    input  logic       init,
    input  logic [7:0] preamble,
    input  logic [3:0] pre_len,
    input  logic [2:0] tap_sel,
    input  logic [4:0] lfsr_seed,
    input  logic       wr_en_tb,
    input  logic [7:0] raddr_tb,
    input  logic [7:0] waddr_tb,
    input  logic [7:0] data_in_tb,
    output logic [7:0] data_out_tb,
    input  logic       mem_tb_control,
    output logic       done
);

    logic [7:0] r_mem [256];
    enc_state_e r_state, w_state_next;
    logic [5:0] r_k, w_k_next;

    logic [4:0] w_lfsr_state, w_lfsr_start, w_taps;
    logic       w_lfsr_en, w_lfsr_init;
    logic [3:0] w_pre_eff;
    logic [7:0] w_src, w_rdata;
    logic [7:0] w_blk_raddr, w_blk_waddr, w_blk_wdata;
    logic       w_blk_wr;
    logic [7:0] w_raddr, w_waddr, w_wdata;
    logic       w_wr;

    assign w_pre_eff = clamp_pre_len(pre_len);
    assign w_taps    = tap_pattern(tap_sel);

    // Read address wraps while k < P; the read is unused then.
    assign w_blk_raddr = 8'(MSG_BASE) + ({2'b00, r_k} - {4'h0, w_pre_eff});
    assign w_blk_waddr = 8'(ENC_BASE) + {2'b00, r_k};
    assign w_src       = (r_k < {2'b00, w_pre_eff}) ? preamble : w_rdata;
    assign w_blk_wdata = {w_src[7:5], w_src[4:0] ^ w_lfsr_state};

    // Memory port ownership.
    assign w_raddr     = mem_tb_control ? raddr_tb   : w_blk_raddr;
    assign w_waddr     = mem_tb_control ? waddr_tb   : w_blk_waddr;
    assign w_wdata     = mem_tb_control ? data_in_tb : w_blk_wdata;
    assign w_wr        = mem_tb_control ? wr_en_tb   : w_blk_wr;
    assign w_rdata     = r_mem[w_raddr];
    assign data_out_tb = w_rdata;

    // Seed 0 would lock the LFSR, so it is replaced by 1; init forces 1 as well.
    assign w_lfsr_init  = init || (r_state == StLoad);
    assign w_lfsr_start = (init || (lfsr_seed == 5'h00)) ? 5'h01 : lfsr_seed;

    lfsr5 u_lfsr (
        .clk   (clk),
        .en    (w_lfsr_en),
        .init  (w_lfsr_init),
        .taps  (w_taps),
        .start (w_lfsr_start),
        .state (w_lfsr_state)
    );

    // Next-state, byte counter and write strobe; stalls while the bench owns memory.
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_blk_wr     = 1'b0;
        w_lfsr_en    = 1'b0;
        case (r_state)
            StIdle: if (!mem_tb_control) w_state_next = StLoad;
            StLoad: w_state_next = StRun;
            StRun: begin
                if (!mem_tb_control) begin
                    w_blk_wr  = 1'b1;
                    w_lfsr_en = 1'b1;
                    w_k_next  = r_k + 6'd1;
                    if (r_k == 6'(MSG_TOTAL - 1)) w_state_next = StDone;
                end
            end
            StDone: w_state_next = StDone;
            default: w_state_next = StIdle;
        endcase
        if (init) begin
            w_state_next = StIdle;
            w_k_next     = 6'd0;
            w_blk_wr     = 1'b0;
            w_lfsr_en    = 1'b0;
        end
    end

    // State and counter registers with synchronous init.
    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= StIdle;
            r_k     <= 6'd0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    // Data memory write port; contents survive init.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_waddr] <= w_wdata;
    end

    assign done = (r_state == StDone);

`ifdef ENC_TRACE_EN
    // Trace each ciphertext write.
    always_ff @(posedge clk) begin
        if (w_blk_wr) begin
            $display("enc: waddr=%0d src=%h data_in=%h", w_blk_waddr, w_src, w_blk_wdata);
        end
    end
`else
`endif

endmodule

// File: tb/tb_encrypter_top_level.sv
// Directed bench for encrypter_top_level with a ciphertext scoreboard queue.
module tb_encrypter_top_level;

    logic       clk = 1'b0;
    logic       init = 1'b1;
    logic [7:0] preamble = 8'h7E;
    logic [3:0] pre_len = 4'd7;
    logic [2:0] tap_sel = 3'd0;
    logic [4:0] lfsr_seed = 5'h01;
    logic       wr_en_tb = 1'b0;
    logic [7:0] raddr_tb = 8'h00;
    logic [7:0] waddr_tb = 8'h00;
    logic [7:0] data_in_tb = 8'h00;
    logic [7:0] data_out_tb;
    logic       mem_tb_control = 1'b1;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] pt [64];
    logic [7:0] expq [$];

    encrypter_top_level dut (
        .clk            (clk),
        .init           (init),
        .preamble       (preamble),
        .pre_len        (pre_len),
        .tap_sel        (tap_sel),
        .lfsr_seed      (lfsr_seed),
        .wr_en_tb       (wr_en_tb),
        .raddr_tb       (raddr_tb),
        .waddr_tb       (waddr_tb),
        .data_in_tb     (data_in_tb),
        .data_out_tb    (data_out_tb),
        .mem_tb_control (mem_tb_control),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_tb_control = 1'b1;
        waddr_tb = a;
        data_in_tb = d;
        wr_en_tb = 1'b1;
        @(negedge clk);
        wr_en_tb = 1'b0;
    endtask

    task automatic tb_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        raddr_tb = a;
        #1;
        d = data_out_tb;
    endtask

    // Reference encoder; bytes past nbytes are expected to keep the 8'hA5 fill.
    task automatic push_expected(input logic [7:0] pre, input logic [3:0] plen,
                                 input logic [2:0] tsel, input logic [4:0] seed,
                                 input int nbytes);
        int p;
        logic [4:0] taps, s;
        logic [7:0] src;
        p = (plen < 6) ? 6 : (plen > 12) ? 12 : int'(plen);
        case (tsel)
            3'd1: taps = 5'h1D;
            3'd2: taps = 5'h1B;
            3'd3: taps = 5'h17;
            3'd4: taps = 5'h14;
            3'd5: taps = 5'h12;
            default: taps = 5'h1E;
        endcase
        s = (seed == 5'h00) ? 5'h01 : seed;
        for (int k = 0; k < 64; k++) begin
            if (k < nbytes) begin
                src = (k < p) ? pre : pt[k - p];
                expq.push_back({src[7:5], src[4:0] ^ s});
                s = {s[3:0], ^(s & taps)};
            end else begin
                expq.push_back(8'hA5);
            end
        end
    endtask

    task automatic prefill_enc();
        for (int a = 64; a < 128; a++) tb_write(8'(a), 8'hA5);
    endtask

    task automatic compare_mem(input string tag);
        logic [7:0] d;
        for (int a = 64; a < 128; a++) begin
            tb_read(8'(a), d);
            if (expq.size() == 0) begin
                check({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                check($sformatf("%s_mem%0d", tag, a), {24'h0, d}, {24'h0, expq.pop_front()});
            end
        end
    endtask

    // Runs one encryption; edges counted from the first edge with init=0.
    task automatic run_enc(input logic [7:0] pre, input logic [3:0] plen,
                           input logic [2:0] tsel, input logic [4:0] seed,
                           input int stall_lo, input int stall_hi, input int abort_edge,
                           output int done_edge);
        @(negedge clk);
        mem_tb_control = 1'b1;
        init = 1'b1;
        preamble = pre;
        pre_len = plen;
        tap_sel = tsel;
        lfsr_seed = seed;
        @(negedge clk);
        @(negedge clk);
        check("done_in_reset", {31'h0, done}, 32'd0);
        init = 1'b0;
        mem_tb_control = 1'b0;
        done_edge = -1;
        for (int e = 1; e <= 200; e++) begin
            mem_tb_control = (e >= stall_lo && e <= stall_hi);
            if (e == abort_edge) init = 1'b1;
            @(negedge clk);
            if (e == abort_edge) begin
                check("abort_done", {31'h0, done}, 32'd0);
                break;
            end
            if (done) begin
                done_edge = e;
                break;
            end
        end
        if (done_edge > 0) begin
            repeat (3) @(negedge clk);
            check("done_hold", {31'h0, done}, 32'd1);
        end
        mem_tb_control = 1'b1;
        init = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int de;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("reset_done", {31'h0, done}, 32'd0);

        for (int i = 0; i < 64; i++) begin
            pt[i] = 8'($urandom);
            tb_write(8'(i), pt[i]);
        end
        for (int a = 128; a < 132; a++) tb_write(8'(a), 8'h3C);

        // Nominal run.
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd7, 3'd0, 5'h01, 0, -1, 0, de);
        check("nominal_done_edge", 32'(de), 32'd66);
        tb_read(8'd64, d);
        check("nominal_mem64", {24'h0, d}, 32'h7F);
        compare_mem("nominal");

        // Seed 0 behaves as seed 1.
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd7, 3'd0, 5'h00, 0, -1, 0, de);
        check("seed0_done_edge", 32'(de), 32'd66);
        compare_mem("seed0");

        // Preamble length clamps.
        prefill_enc();
        push_expected(8'h7E, 4'd6, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd3, 3'd0, 5'h01, 0, -1, 0, de);
        compare_mem("prelen3");

        prefill_enc();
        push_expected(8'h7E, 4'd12, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd15, 3'd0, 5'h01, 0, -1, 0, de);
        compare_mem("prelen15");

        // tap_sel 7 behaves as 0.
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd7, 3'd7, 5'h01, 0, -1, 0, de);
        compare_mem("tap7");

        // Other taps, preamble and seed.
        prefill_enc();
        push_expected(8'hC3, 4'd12, 3'd4, 5'h13, 64);
        run_enc(8'hC3, 4'd12, 3'd4, 5'h13, 0, -1, 0, de);
        compare_mem("tap4");

        prefill_enc();
        push_expected(8'h5A, 4'd6, 3'd2, 5'h1F, 64);
        run_enc(8'h5A, 4'd6, 3'd2, 5'h1F, 0, -1, 0, de);
        compare_mem("tap2");

        // Stall over RUN cycles 10..14 (edges 13..17).
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd0, 5'h01, 64);
        run_enc(8'h7E, 4'd7, 3'd0, 5'h01, 13, 17, 0, de);
        check("stall_done_edge", 32'(de), 32'd71);
        compare_mem("stall");

        // Abort at RUN cycle 20 (edge 23): 20 bytes written, rest untouched.
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd3, 5'h09, 20);
        run_enc(8'h7E, 4'd7, 3'd3, 5'h09, 0, -1, 23, de);
        check("abort_no_done", 32'(de), 32'hFFFF_FFFF);
        compare_mem("abort");

        // Restart from IDLE after the abort.
        prefill_enc();
        push_expected(8'h7E, 4'd7, 3'd1, 5'h05, 64);
        run_enc(8'h7E, 4'd7, 3'd1, 5'h05, 0, -1, 0, de);
        check("restart_done_edge", 32'(de), 32'd66);
        compare_mem("restart");

        // Plaintext and memory above 127 never written by the block.
        for (int a = 0; a < 64; a += 9) begin
            tb_read(8'(a), d);
            check($sformatf("plain%0d", a), {24'h0, d}, {24'h0, pt[a]});
        end
        for (int a = 128; a < 132; a++) begin
            tb_read(8'(a), d);
            check($sformatf("high%0d", a), {24'h0, d}, 32'h3C);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
